sr_drive_ctrl: RTL and testbench
================================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a button level change; legal range 2..255.
REQ-002 Parameter PULSE_CYCLES, default 2: cycles s or r is held high per command; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_set  input  1  raw asynchronous set pushbutton, active-high.
REQ-006 btn_rst  input  1  raw asynchronous reset pushbutton, active-high.
REQ-007 q_fb  input  1  q output fed back from the downstream SR latch.
REQ-008 s  output  1  set drive to latch, registered.
REQ-009 r  output  1  reset drive to latch, registered.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 err  output  1  sticky flag: latch did not follow a command.

Function
REQ-012 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-013 Per button, a debounced level db SHALL change to the synchronized value only after DEBOUNCE_CYCLES consecutive samples differing from db; any matching sample clears that counter.
REQ-014 A set request SHALL be raised in the cycle db_set rises, a reset request in the cycle db_rst rises; falling edges raise nothing.
REQ-015 FSM states: IDLE, PULSE_S, PULSE_R, GAP; s=1 only in PULSE_S, r=1 only in PULSE_R, never both high in any cycle.
REQ-016 IDLE -> PULSE_R on reset request or pending reset; else IDLE -> PULSE_S on set request or pending set.
REQ-017 PULSE_S/PULSE_R SHALL last exactly PULSE_CYCLES cycles, then go to GAP.
REQ-018 GAP SHALL last exactly 1 cycle with s=r=0, then go to IDLE.
REQ-019 Simultaneous set and reset requests in IDLE: reset wins, set request discarded.
REQ-020 Requests arriving while not IDLE SHALL set a one-deep pending flag per type; repeats while pending are merged; a pending flag clears when its pulse starts.
REQ-021 If both pending flags are set on return to IDLE, reset is served first, then set after its own pulse and GAP.
REQ-022 In the GAP cycle, err SHALL be set if q_fb != 1 after a set pulse or q_fb != 0 after a reset pulse; err clears only on reset.
REQ-023 Latency (defaults): button high before edge 0 -> s high from edge 6 through edge 8 -> GAP from edge 8 -> IDLE from edge 9.

Reset
REQ-024 While rst_n=0: s=0, r=0, busy=0, err=0, FSM=IDLE, synchronizers/db=0, counters=0, pending flags cleared.
REQ-025 Reset asserted mid-pulse SHALL drop s/r immediately (asynchronously) and discard all pending requests.
REQ-026 After rst_n deasserts, a button already held high SHALL be treated as a new rising level and produce one command after the normal debounce latency.

Verification
REQ-027 btn_set held high, q_fb follows s -> s=1 for 2 cycles starting edge 6, r=0 throughout, busy=1 for 3 cycles, err=0.
REQ-028 btn_set toggling every 2 cycles for 20 cycles, then low -> no s pulse, busy stays 0.
REQ-029 btn_set and btn_rst rise in the same cycle -> single r pulse of 2 cycles, no s pulse.
REQ-030 btn_rst pressed during an s pulse -> s pulse completes, GAP with s=r=0, then r pulse of 2 cycles.
REQ-031 Set pulse with q_fb tied to 0 -> err=1 in the cycle after GAP and remains 1 until rst_n=0.
REQ-032 rst_n pulsed low during PULSE_S -> s=0 within the reset-low window, busy=0, no later r/s pulse from discarded requests.

Source files
------------

// File: rtl/sr_drive_ctrl_if.sv
// Signal bundle between the SR-latch drive controller and its surroundings:
// raw pushbuttons and latch feedback in, latch drives and status out.
interface sr_drive_ctrl_if;
    logic btn_set;
    logic btn_rst;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic err;

    // Environment side: drives buttons and latch feedback, observes drives/status
    modport master (
        output btn_set, btn_rst, q_fb,
        input  s, r, busy, err
    );

    // Controller side
    modport slave (
        input  btn_set, btn_rst, q_fb,
        output s, r, busy, err
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// SR latch drive controller: synchronizes and debounces two pushbuttons,
// turns their rising debounced levels into fixed-width set/reset pulses with
// a guard gap, queues one request of each type while busy (reset first), and
// flags a sticky error when the latch feedback does not follow a command.
module sr_drive_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_drive_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_e;

    localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

    // Bit 0 carries the set button, bit 1 the reset button.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_prev_q, db_prev_d;
    logic [1:0][7:0] db_cnt_q, db_cnt_d;

    state_e     state_q, state_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       pend_s_q, pend_s_d;
    logic       pend_r_q, pend_r_d;
    logic       last_set_q, last_set_d;
    logic       err_q, err_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       busy_q, busy_d;

    logic set_req_s;
    logic rst_req_s;

    // Input conditioning: two-flop synchronizers and per-button debounce counters
    always_comb begin
        sync1_d   = {bus.btn_rst, bus.btn_set};
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        db_cnt_d  = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = 8'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end else begin
                db_cnt_d[i] = 8'd0;
            end
        end
    end

    // Only rising debounced levels produce commands
    assign set_req_s = db_q[0] & ~db_prev_q[0];
    assign rst_req_s = db_q[1] & ~db_prev_q[1];

    // Command sequencing: pulse selection, pending requests and feedback check
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        pend_s_d   = pend_s_q;
        pend_r_d   = pend_r_q;
        last_set_d = last_set_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (rst_req_s || pend_r_q) begin
                    state_d    = PULSE_R;
                    pcnt_d     = 4'd0;
                    pend_r_d   = 1'b0;
                    last_set_d = 1'b0;
                    // a fresh set arriving alongside a queued reset is kept;
                    // one arriving alongside a fresh reset is dropped
                    if (set_req_s && !rst_req_s) begin
                        pend_s_d = 1'b1;
                    end else begin
                        pend_s_d = pend_s_q;
                    end
                end else if (set_req_s || pend_s_q) begin
                    state_d    = PULSE_S;
                    pcnt_d     = 4'd0;
                    pend_s_d   = 1'b0;
                    last_set_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE_S, PULSE_R: begin
                pend_s_d = pend_s_q | set_req_s;
                pend_r_d = pend_r_q | rst_req_s;
                if (pcnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    pcnt_d  = 4'd0;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            GAP: begin
                pend_s_d = pend_s_q | set_req_s;
                pend_r_d = pend_r_q | rst_req_s;
                state_d  = IDLE;
                if (bus.q_fb != last_set_q) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        s_d    = (state_d == PULSE_S);
        r_d    = (state_d == PULSE_R);
        busy_d = (state_d != IDLE);
    end

    // Input conditioning registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            db_q      <= 2'b00;
            db_prev_q <= 2'b00;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

    // Sequencer state and registered outputs; reset drops s/r at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pcnt_q     <= 4'd0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            last_set_q <= 1'b0;
            err_q      <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_s_q   <= pend_s_d;
            pend_r_q   <= pend_r_d;
            last_set_q <= last_set_d;
            err_q      <= err_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl. A timing model built from edge
// numbers (debounce sample counts, "free from" edge of the sequencer, pending
// booleans) pushes one expected pulse per command into a queue; a monitor on
// the falling clock edge pops and compares whenever s or r rises, and checks
// busy/err/exclusivity every cycle.
module tb_sr_drive_ctrl;
    localparam int DB = 4;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst_n;

    sr_drive_ctrl_if ifc ();

    sr_drive_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_set;
        int start;
    } pulse_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fb_mode = 0;   // 0: latch follows s/r, 1: q_fb stuck 0, 2: q_fb stuck 1
    logic q_lat = 1'b0;

    // reference model state
    int  m_s1[2];
    int  m_s2[2];
    int  m_db[2];
    int  m_cnt[2];
    bit  m_req[2];
    bit  pend_s, pend_r, exp_err;
    int  free_edge, act_start, err_edge;
    pulse_t exp_q[$];

    // monitor state
    bit  prev_s, prev_r, in_pulse;
    int  pulse_start, s_pulses, r_pulses, busy_cnt, last_s_start, last_r_start;
    pulse_t mon_p;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_busy();
        return ((cyc >= act_start) && (cyc <= act_start + PL)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_cnt[i] = 0; m_req[i] = 1'b0;
        end
        pend_s = 1'b0; pend_r = 1'b0; exp_err = 1'b0;
        free_edge = 0; act_start = -1000000; err_edge = -1;
        exp_q.delete();
    endtask

    task automatic start_pulse(input bit is_set, input int e);
        pulse_t p;
        p.is_set = is_set;
        p.start  = e;
        exp_q.push_back(p);
        act_start = e;
        free_edge = e + PL + 2;          // PL pulse cycles + 1 gap + 1 idle
        if (((is_set && fb_mode == 1) || (!is_set && fb_mode == 2)) && err_edge < 0)
            err_edge = e + PL + 1;
    endtask

    // Reference model: advances one clock edge, reset clears everything at once
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int b[2];
            cyc++;
            // requests raised in the cycle that just ended are served now
            if (cyc >= free_edge) begin
                if (m_req[1] || pend_r) begin
                    if (m_req[0] && !m_req[1]) pend_s = 1'b1;
                    pend_r = 1'b0;
                    start_pulse(1'b0, cyc);
                end else if (m_req[0] || pend_s) begin
                    pend_s = 1'b0;
                    start_pulse(1'b1, cyc);
                end
            end else begin
                pend_s = pend_s | m_req[0];
                pend_r = pend_r | m_req[1];
            end
            b[0] = int'(ifc.btn_set);
            b[1] = int'(ifc.btn_rst);
            for (int i = 0; i < 2; i++) begin
                m_req[i] = 1'b0;
                if (m_s2[i] != m_db[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DB) begin
                        m_db[i]  = m_s2[i];
                        m_cnt[i] = 0;
                        m_req[i] = (m_db[i] == 1);
                    end
                end else begin
                    m_cnt[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = b[i];
            end
            if (err_edge >= 0 && cyc >= err_edge) exp_err = 1'b1;
        end
    end

    // Latch feedback stimulus
    always @(negedge clk) begin
        if (fb_mode == 0) begin
            if (ifc.s) q_lat = 1'b1;
            else if (ifc.r) q_lat = 1'b0;
            ifc.q_fb = q_lat;
        end else begin
            ifc.q_fb = (fb_mode == 2);
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_s", int'(ifc.s), 0);
            check("rst_r", int'(ifc.r), 0);
            check("rst_busy", int'(ifc.busy), 0);
            check("rst_err", int'(ifc.err), 0);
            in_pulse = 1'b0; prev_s = 1'b0; prev_r = 1'b0;
        end else begin
            check("s_r_excl", int'(ifc.s & ifc.r), 0);
            check("busy", int'(ifc.busy), exp_busy());
            check("err", int'(ifc.err), int'(exp_err));
            if (ifc.busy) busy_cnt++;
            if ((ifc.s && !prev_s) || (ifc.r && !prev_r)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    mon_p = exp_q.pop_front();
                    check("pulse_type_is_set", int'(ifc.s), int'(mon_p.is_set));
                    check("pulse_start", cyc, mon_p.start);
                end
                in_pulse = 1'b1;
                pulse_start = cyc;
                if (ifc.s) begin s_pulses++; last_s_start = cyc; end
                else begin r_pulses++; last_r_start = cyc; end
            end
            if (in_pulse && ((prev_s && !ifc.s) || (prev_r && !ifc.r))) begin
                check("pulse_len", cyc - pulse_start, PL);
                in_pulse = 1'b0;
            end
            prev_s = ifc.s;
            prev_r = ifc.r;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int t0, s0, r0;
        rst_n = 1'b0;
        ifc.btn_set = 1'b0;
        ifc.btn_rst = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // set held high, latch follows: latency, width, busy length
        busy_cnt = 0; s0 = s_pulses; r0 = r_pulses; t0 = cyc;
        ifc.btn_set = 1'b1;
        tick(15);
        check("set_latency", last_s_start - t0, 7);
        check("set_busy_cycles", busy_cnt, 3);
        check("set_s_count", s_pulses - s0, 1);
        check("set_r_count", r_pulses - r0, 0);
        check("set_err", int'(ifc.err), 0);
        ifc.btn_set = 1'b0;
        tick(12);

        // bouncing button never settles
        busy_cnt = 0; s0 = s_pulses;
        for (int i = 0; i < 10; i++) begin
            ifc.btn_set = ~ifc.btn_set;
            tick(2);
        end
        ifc.btn_set = 1'b0;
        tick(12);
        check("bounce_busy", busy_cnt, 0);
        check("bounce_s_count", s_pulses - s0, 0);

        // simultaneous set and reset: reset wins
        s0 = s_pulses; r0 = r_pulses;
        ifc.btn_set = 1'b1; ifc.btn_rst = 1'b1;
        tick(15);
        check("both_r_count", r_pulses - r0, 1);
        check("both_s_count", s_pulses - s0, 0);
        ifc.btn_set = 1'b0; ifc.btn_rst = 1'b0;
        tick(12);

        // reset pressed during a set pulse: served after pulse + gap
        s0 = s_pulses; r0 = r_pulses;
        ifc.btn_set = 1'b1;
        tick(2);
        ifc.btn_rst = 1'b1;
        tick(20);
        check("queued_s_count", s_pulses - s0, 1);
        check("queued_r_count", r_pulses - r0, 1);
        check("queued_r_after_s", last_r_start - last_s_start, PL + 2);
        ifc.btn_set = 1'b0; ifc.btn_rst = 1'b0;
        tick(12);

        // latch stuck at 0: sticky error after a set pulse
        fb_mode = 1;
        ifc.btn_set = 1'b1;
        tick(15);
        check("stuck_err", int'(ifc.err), 1);
        ifc.btn_set = 1'b0;
        tick(10);
        check("stuck_err_hold", int'(ifc.err), 1);
        fb_mode = 0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("err_cleared", int'(ifc.err), 0);

        // reset during a set pulse with a reset request queued
        s0 = s_pulses; r0 = r_pulses;
        ifc.btn_set = 1'b1;
        tick(1);
        ifc.btn_rst = 1'b1;
        tick(7);
        check("pre_abort_s", int'(ifc.s), 1);
        rst_n = 1'b0;
        ifc.btn_set = 1'b0; ifc.btn_rst = 1'b0;
        #1;
        check("abort_s_drop", int'(ifc.s), 0);
        check("abort_busy_drop", int'(ifc.busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("abort_s_count", s_pulses - s0, 1);
        check("abort_r_count", r_pulses - r0, 0);

        // button held through reset counts as a new press
        s0 = s_pulses;
        ifc.btn_set = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        t0 = cyc;
        tick(15);
        check("held_s_count", s_pulses - s0, 1);
        check("held_latency", last_s_start - t0, 7);
        ifc.btn_set = 1'b0;
        tick(12);

        // randomized button activity with occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) ifc.btn_set = ~ifc.btn_set;
            if ($urandom_range(0, 3) == 0) ifc.btn_rst = ~ifc.btn_rst;
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick($urandom_range(1, 10));
        end
        ifc.btn_set = 1'b0; ifc.btn_rst = 1'b0;
        tick(30);
        check("drain_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
